// File: rtl/pad_pkg.sv
// ---------------------------------------------------------------------------
// pad_pkg
// Shared definitions for the dance-pad input front end: event codes, button
// index order (matches the bit order of `held`) and the fixed-priority
// encoder used to serialize simultaneous presses.
// ---------------------------------------------------------------------------
package pad_pkg;

    typedef logic [1:0] ev_code_t;

    localparam ev_code_t EV_UP    = 2'd0;
    localparam ev_code_t EV_DOWN  = 2'd1;
    localparam ev_code_t EV_LEFT  = 2'd2;
    localparam ev_code_t EV_RIGHT = 2'd3;

    localparam int BTN_UP    = 0;
    localparam int BTN_DOWN  = 1;
    localparam int BTN_LEFT  = 2;
    localparam int BTN_RIGHT = 3;
    localparam int NUM_BTN   = 4;

    // Lowest set index wins: up > down > left > right.
    function automatic ev_code_t prio_code(input logic [NUM_BTN-1:0] pend);
        ev_code_t code;
        code = EV_UP;
        for (int i = NUM_BTN - 1; i >= 0; i--) begin
            if (pend[i]) begin
                code = ev_code_t'(i);
            end
        end
        return code;
    endfunction

endpackage

// File: rtl/pad_event_source_if.sv
// ---------------------------------------------------------------------------
// pad_event_source_if
// Valid/ready event channel between the pad front end (master) and the
// state controller (slave).
//   ev_valid : head of the event queue holds an event
//   ev_code  : head event code (pad_pkg EV_* values)
//   ev_ready : consumer accepts the head event this cycle
// ---------------------------------------------------------------------------
interface pad_event_source_if;
    import pad_pkg::*;

    logic     ev_valid;
    ev_code_t ev_code;
    logic     ev_ready;

    modport master (output ev_valid, output ev_code, input ev_ready);
    modport slave  (input ev_valid, input ev_code, output ev_ready);

endinterface

// File: rtl/pad_debounce.sv
// ---------------------------------------------------------------------------
// pad_debounce
// One pad button: 2-flop synchronizer, run-length debounce counter, stable
// level and a one-cycle pulse on each accepted 0->1 change of the stable level.
//   clk, rst : system clock, asynchronous active-low reset
//   raw      : raw asynchronous button input
//   stable   : debounced level
//   rise     : high for one cycle, the cycle after stable goes 0->1
// ---------------------------------------------------------------------------
module pad_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic stable,
    output logic rise
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             stable_q, stable_d;
    logic             stable_prev_q, stable_prev_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d       = raw;
        sync2_d       = sync1_q;
        stable_d      = stable_q;
        stable_prev_d = stable_q;
        cnt_d         = '0;
        // Any cycle where the synchronized level agrees with stable restarts
        // the run; DEBOUNCE_CYCLES consecutive disagreements accept it.
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            stable_q      <= 1'b0;
            stable_prev_q <= 1'b0;
            cnt_q         <= '0;
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            stable_q      <= stable_d;
            stable_prev_q <= stable_prev_d;
            cnt_q         <= cnt_d;
        end
    end

    assign stable = stable_q;
    assign rise   = stable_q & ~stable_prev_q;

endmodule

// File: rtl/pad_event_source.sv
// ---------------------------------------------------------------------------
// pad_event_source
// Debounces the four pad buttons, latches each press into a pending bit,
// serializes pending presses in priority order into a small first-word-
// fall-through FIFO and offers the head over a valid/ready channel.
//   clk, rst        : system clock, asynchronous active-low reset
//   btn_*           : raw asynchronous active-high pad inputs
//   held            : debounced levels {right, left, down, up}
//   overflow        : sticky, a press merged into one already pending
//   ev_if (master)  : event channel (ev_valid, ev_code, ev_ready)
// ---------------------------------------------------------------------------
module pad_event_source
    import pad_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    btn_up,
    input  logic                    btn_down,
    input  logic                    btn_left,
    input  logic                    btn_right,
    output logic [NUM_BTN-1:0]      held,
    output logic                    overflow,
    pad_event_source_if.master      ev_if
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] stable;
    logic [NUM_BTN-1:0] rise;

    assign btn_raw = {btn_right, btn_left, btn_down, btn_up};

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        pad_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk    (clk),
            .rst    (rst),
            .raw    (btn_raw[i]),
            .stable (stable[i]),
            .rise   (rise[i])
        );
    end

    ev_code_t           mem_q [FIFO_DEPTH];
    ev_code_t           mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [NUM_BTN-1:0] pend_q, pend_d;
    logic               overflow_q, overflow_d;

    logic     full;
    logic     empty;
    logic     push;
    logic     pop;
    ev_code_t grant_code;

    always_comb begin
        full       = (count_q == CNT_FULL);
        empty      = (count_q == '0);
        pop        = !empty && ev_if.ev_ready;
        // Fullness is judged before the pop, so a full FIFO never takes a
        // push in the same cycle it is popped.
        push       = !full && (|pend_q);
        grant_code = prio_code(pend_q);

        pend_d     = pend_q;
        overflow_d = overflow_q;
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;

        if (push) begin
            pend_d[grant_code] = 1'b0;
            mem_d[wr_ptr_q]    = grant_code;
            wr_ptr_d           = wr_ptr_q + 1'b1;
        end

        // A new press wins over the grant clear; it only counts as lost if
        // the old pending press is still sitting there after this edge.
        for (int i = 0; i < NUM_BTN; i++) begin
            if (rise[i]) begin
                if (pend_q[i] && !(push && grant_code == ev_code_t'(i))) begin
                    overflow_d = 1'b1;
                end
                pend_d[i] = 1'b1;
            end
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= EV_UP;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            pend_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            pend_q     <= pend_d;
            overflow_q <= overflow_d;
        end
    end

    assign ev_if.ev_valid = !empty;
    // Stale entries are masked so an idle channel shows code 0.
    assign ev_if.ev_code  = empty ? EV_UP : mem_q[rd_ptr_q];
    assign held           = stable;
    assign overflow       = overflow_q;

endmodule

// File: tb/tb_pad_event_source.sv
module tb_pad_event_source;
    import pad_pkg::*;

    localparam int DC   = 4;
    localparam int D    = 4;
    localparam int MAXE = 20000;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
    logic [3:0] held;
    logic       overflow;

    pad_event_source_if ev_if ();

    pad_event_source #(
        .DEBOUNCE_CYCLES(DC),
        .FIFO_DEPTH     (D)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .btn_left  (btn_left),
        .btn_right (btn_right),
        .held      (held),
        .overflow  (overflow),
        .ev_if     (ev_if)
    );

    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Behavioural view: a button's debounced level flips once its synchronized
    // input (raw delayed two edges) has disagreed with it for DC consecutive
    // edges since the last flip / reset. A flip to 1 becomes a pending press
    // one edge later; the queue takes the lowest pending index while it has
    // fewer than D entries.
    logic [3:0] hist [MAXE];
    int         e = 0;
    int         first_edge = 0;
    int         last_flip [4];
    logic [3:0] m_stable = '0;
    logic [3:0] rise_next = '0;
    logic [3:0] m_pend = '0;
    logic       m_ovf = 1'b0;
    int         mq[$];
    int         exp_q[$];
    int         old_size;
    int         g;
    bit         flip_ok;

    function automatic logic synced(input int b, input int n);
        if (n - 2 >= first_edge) return hist[n-2][b];
        return 1'b0;
    endfunction

    initial begin
        for (int b = 0; b < 4; b++) last_flip[b] = -1;
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mq.delete();
            exp_q.delete();
            m_pend     = '0;
            m_stable   = '0;
            rise_next  = '0;
            m_ovf      = 1'b0;
            first_edge = e;
            for (int b = 0; b < 4; b++) last_flip[b] = e - 1;
        end else begin
            hist[e] = {btn_right, btn_left, btn_down, btn_up};
            old_size = mq.size();
            g = -1;
            if (old_size > 0 && ev_if.ev_ready) void'(mq.pop_front());
            if (old_size < D) begin
                for (int b = 3; b >= 0; b--) if (m_pend[b]) g = b;
                if (g >= 0) begin
                    mq.push_back(g);
                    exp_q.push_back(g);
                    m_pend[g] = 1'b0;
                end
            end
            for (int b = 0; b < 4; b++) begin
                if (rise_next[b]) begin
                    if (m_pend[b] && b != g) m_ovf = 1'b1;
                    m_pend[b] = 1'b1;
                end
            end
            rise_next = '0;
            for (int b = 0; b < 4; b++) begin
                flip_ok = 1'b1;
                for (int j = 0; j < DC; j++) begin
                    if ((e - j) <= last_flip[b] || synced(b, e - j) == m_stable[b]) flip_ok = 1'b0;
                end
                if (flip_ok) begin
                    m_stable[b]  = ~m_stable[b];
                    last_flip[b] = e;
                    if (m_stable[b]) rise_next[b] = 1'b1;
                end
            end
            e++;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        check("ev_valid", int'(ev_if.ev_valid), int'(mq.size() != 0));
        check("held", int'(held), int'(m_stable));
        check("overflow", int'(overflow), int'(m_ovf));
        if (ev_if.ev_valid) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL ev_code: got %0d expected no event at %0t", ev_if.ev_code, $time);
            end else begin
                check("ev_code", int'(ev_if.ev_code), exp_q[0]);
                if (ev_if.ev_ready) void'(exp_q.pop_front());
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_btns(input logic [3:0] v);
        {btn_right, btn_left, btn_down, btn_up} = v;
    endtask

    task automatic latency(input string name, input int exp);
        int n;
        n = 0;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk);
            #1;
            if (ev_if.ev_valid) begin
                n = i;
                break;
            end
        end
        if (n == 0) n = 99;
        check(name, n, exp);
    endtask

    logic [3:0] rnd_btn;

    initial begin
        ev_if.ev_ready = 1'b1;
        tick(3);
        rst = 1'b1;
        tick(3);

        // single press
        set_btns(4'b0100);
        latency("left_latency", DC + 4);
        tick(12);
        set_btns(4'b0000);
        tick(10);

        // glitch
        set_btns(4'b0001);
        tick(3);
        set_btns(4'b0000);
        tick(12);

        // simultaneous press with backpressure, then drain
        ev_if.ev_ready = 1'b0;
        set_btns(4'b1111);
        tick(12);
        set_btns(4'b0000);
        tick(10);
        ev_if.ev_ready = 1'b1;
        tick(8);

        // overflow: fill, then press down twice while full
        ev_if.ev_ready = 1'b0;
        set_btns(4'b1111);
        tick(10);
        set_btns(4'b0000);
        tick(10);
        set_btns(4'b0010);
        tick(9);
        set_btns(4'b0000);
        tick(9);
        set_btns(4'b0010);
        tick(9);
        set_btns(4'b0000);
        tick(9);
        ev_if.ev_ready = 1'b1;
        tick(10);

        // backpressure stability
        ev_if.ev_ready = 1'b0;
        set_btns(4'b1000);
        tick(10);
        set_btns(4'b0000);
        tick(10);
        ev_if.ev_ready = 1'b1;
        tick(4);

        // reset mid-operation
        ev_if.ev_ready = 1'b0;
        set_btns(4'b0011);
        tick(10);
        set_btns(4'b0100);
        tick(3);
        rst = 1'b0;
        #1;
        check("rst_async_valid", int'(ev_if.ev_valid), 0);
        check("rst_async_held", int'(held), 0);
        check("rst_async_overflow", int'(overflow), 0);
        tick(2);
        set_btns(4'b0000);
        rst = 1'b1;
        ev_if.ev_ready = 1'b1;
        tick(20);
        set_btns(4'b1000);
        latency("right_latency_after_rst", DC + 4);
        tick(6);
        set_btns(4'b0000);
        tick(10);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            rnd_btn = {btn_right, btn_left, btn_down, btn_up};
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 7) == 0) rnd_btn[b] = ~rnd_btn[b];
            end
            set_btns(rnd_btn);
            if ((c / 200) % 2 == 0) ev_if.ev_ready = ($urandom_range(0, 3) != 0);
            else                    ev_if.ev_ready = ($urandom_range(0, 5) == 0);
            tick(1);
        end

        set_btns(4'b0000);
        ev_if.ev_ready = 1'b1;
        tick(40);
        check("leftover_events", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
